rr_resource_sched: RTL and testbench
====================================

Name: rr_resource_sched

Overview:
- Round-robin scheduler that shares one datapath resource (e.g. the step/compare engine) among N requesters.
- Grants exclusive ownership to one requester at a time, bounded by a hold timeout so every persistent requester is eventually served.
- Sits between the requester ports and the shared engine; drives the engine's select and enable.
- Written for both simulation and formal checking: safety (mutual exclusion) and liveness (no starvation) are first-class requirements.

Parameters:
- N, 4, number of requesters; legal range 2..8.
- IDW, 2, width of gnt_id; must equal clog2(N).
- MAX_HOLD, 6, maximum cycles a grant may remain in state GRANT before forced release; legal range 1..255.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous reset, active-high.
- req  input  N  request per requester; level-sensitive.
- done  input  N  completion pulse per requester; only done[gnt_id] is honoured, and only in GRANT.
- gnt  output  N  one-hot grant, registered; all-zero when nobody owns the resource.
- gnt_id  output  IDW  index of current owner; valid only while busy=1.
- busy  output  1  high exactly when gnt is non-zero.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0.
  - ptr=0 (highest-priority index), hold_cnt=0.
  - Reset mid-grant drops the grant in the same edge; no done or timeout is emitted.
- States are IDLE, GRANT and RELEASE.
- IDLE:
  - If req != 0, pick the winner as the first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - At the next posedge: gnt=onehot(winner), gnt_id=winner, busy=1, hold_cnt=0, state=GRANT.
  - Latency from req rise (seen in IDLE) to gnt is 1 cycle.
  - If req == 0, stay in IDLE.
- GRANT:
  - hold_cnt increments by 1 each cycle, saturating at MAX_HOLD.
  - Release condition: done[gnt_id]=1, OR req[gnt_id]=0 (withdrawal), OR hold_cnt==MAX_HOLD-1 (forced).
  - On release at the next posedge: gnt=0, busy=0, state=RELEASE, ptr=(gnt_id+1) mod N.
  - timeout=1 for that one cycle only when release is forced and neither done nor withdrawal was present.
  - When done and the limit coincide, done wins and timeout stays 0.
  - done bits of non-owners are ignored.
  - A grant therefore lasts at least 1 and at most MAX_HOLD cycles.
- RELEASE:
  - One dead cycle with gnt=0 to guarantee break-before-make on the shared engine select.
  - Always moves to IDLE. timeout returns to 0.
- Arbitration ordering:
  - ptr wraps modulo N; for non-power-of-2 N, values >= N never occur.
  - The releasing owner has the lowest priority in the next arbitration.
- Invariants (embedded as assertions):
  - $onehot0(gnt).
  - busy == (gnt != 0).
  - gnt only in GRANT.
  - gnt_id < N while busy.
  - timeout implies the previous state was GRANT.
- Liveness (embedded, checked with rst held low after the first cycle):
  - Each requester i that holds req[i]=1 continuously is granted within N*(MAX_HOLD+2) cycles.
  - Also expressed as always s_eventually (busy==0).
- Bound: worst-case cycle between grants to the same persistent requester is N*(MAX_HOLD+2).

Test Plan:
- Reset then single request: rst high 2 cycles, req=4'b0100 -> gnt=4'b0100, gnt_id=2 one cycle later. done[2] on the 3rd grant cycle -> gnt=0 next cycle, RELEASE, IDLE; ptr=3, timeout stays 0.
- Round-robin rotation: req=4'b1111 held, each owner pulses done on its 1st grant cycle -> grant order 0,1,2,3,0. Exactly one gap cycle with gnt=0 and one cycle in IDLE between grants.
- Forced timeout: req=4'b0001 held, no done -> gnt held exactly MAX_HOLD=6 cycles, then timeout=1 for one cycle with gnt=0. Regrant to 0 two cycles later.
- Simultaneous done and limit: done[gnt_id] asserted on the cycle hold_cnt==5 -> release with timeout=0.
- Withdrawal and ignored done: owner 1 drops req mid-grant -> release next edge. done[3] asserted while owner is 1 -> no effect.
- Reset mid-grant, plus formal: rst during GRANT -> gnt=0, ptr=0, state IDLE next edge, no timeout. Separately, formal proof of all invariants and of starvation-freedom for N=4 within 32 cycles.

Source files
------------

// File: rtl/rr_resource_sched.sv
// Round-robin owner scheduler for one shared engine: one-hot registered grant,
// hold timeout, and a dead RELEASE cycle between owners for break-before-make.
module rr_resource_sched #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout,
    output logic [1:0]     dbg_state,
    output logic [IDW-1:0] dbg_ptr
);
    // Requester handshake: req is a level held until ownership is no longer
    // needed; done is a one-cycle pulse honoured only from the current owner.
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;

    localparam int PW = IDW + 1;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [7:0]     hold_q, hold_d;
    logic           timeout_q, timeout_d;

    logic           found;
    logic [IDW-1:0] winner;
    logic [PW-1:0]  cand;
    logic [PW-1:0]  next_ptr;
    logic           owner_done, owner_drop, at_limit;

    // Rotating first-set scan starting at ptr_q.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < N; i++) begin
            cand = PW'(ptr_q) + PW'(i);
            if (cand >= PW'(N)) cand = cand - PW'(N);
            if (!found && req[cand[IDW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        next_ptr = PW'(gnt_id_q) + PW'(1);
        if (next_ptr >= PW'(N)) next_ptr = '0;
    end

    assign owner_done = done[gnt_id_q];
    assign owner_drop = !req[gnt_id_q];
    assign at_limit   = (hold_q == 8'(MAX_HOLD - 1));

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d    = {{(N-1){1'b0}}, 1'b1} << winner;
                    gnt_id_d = winner;
                    hold_d   = '0;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                hold_d = (hold_q == 8'(MAX_HOLD)) ? hold_q : hold_q + 8'd1;
                if (owner_done || owner_drop || at_limit) begin
                    gnt_d     = '0;
                    ptr_d     = next_ptr[IDW-1:0];
                    state_d   = RELEASE;
                    timeout_d = !owner_done && !owner_drop;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign busy      = |gnt_q;
    assign timeout   = timeout_q;
    assign dbg_state = state_q;
    assign dbg_ptr   = ptr_q;

`ifndef SYNTHESIS
    // Cycles each requester has been waiting with req held and no grant.
    logic [15:0] wait_q [N];
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst || !req[i] || gnt_q[i]) wait_q[i] <= '0;
            else if (wait_q[i] != 16'hffff) wait_q[i] <= wait_q[i] + 16'd1;
        end
    end

    a_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_busy:    assert property (@(posedge clk) disable iff (rst) busy == (gnt_q != '0));
    a_gnt_st:  assert property (@(posedge clk) disable iff (rst) (gnt_q != '0) |-> (state_q == GRANT));
    a_id_rng:  assert property (@(posedge clk) disable iff (rst) busy |-> (int'(gnt_id_q) < N));
    a_ptr_rng: assert property (@(posedge clk) disable iff (rst) int'(ptr_q) < N);
    a_tmo:     assert property (@(posedge clk) disable iff (rst) timeout_q |-> ($past(state_q) == GRANT));
    a_hold:    assert property (@(posedge clk) disable iff (rst) (state_q == GRANT) |-> (hold_q < 8'(MAX_HOLD)));

    for (genvar g = 0; g < N; g++) begin : g_live
        a_live: assert property (@(posedge clk) disable iff (rst)
                                 wait_q[g] < 16'(N * (MAX_HOLD + 2)));
    end
`endif
endmodule

// File: tb/tb_rr_resource_sched.sv
// Directed bench for rr_resource_sched (N=4, MAX_HOLD=6) with hand-computed expectations.
module tb_rr_resource_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;
    logic [1:0] dbg_state;
    logic [1:0] dbg_ptr;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_GRANT = 2'd1, S_REL = 2'd2;

    rr_resource_sched #(.N(4), .IDW(2), .MAX_HOLD(6)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout),
        .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; done = '0;
        tick(); tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
        total++; if (gnt_id !== 2'd0) begin bad++; $display("FAIL reset_gnt_id got=%0d want=0", gnt_id); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
        total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
        total++; if (dbg_ptr !== 2'd0) begin bad++; $display("FAIL reset_ptr got=%0d want=0", dbg_ptr); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        req = 4'b0100;
        tick();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b want=0100", gnt); end
        total++; if (gnt_id !== 2'd2) begin bad++; $display("FAIL single_id got=%0d want=2", gnt_id); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
        tick();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_hold2 got=%b want=0100", gnt); end
        tick();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_hold3 got=%b want=0100", gnt); end
        done = 4'b0100;
        tick();
        done = '0; req = '0;
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_rel_gnt got=%b want=0000", gnt); end
        total++; if (dbg_state !== S_REL) begin bad++; $display("FAIL single_rel_state got=%0d want=2", dbg_state); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL single_rel_tmo got=%b want=0", timeout); end
        tick();
        total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL single_idle got=%0d want=0", dbg_state); end
        total++; if (dbg_ptr !== 2'd3) begin bad++; $display("FAIL single_ptr got=%0d want=3", dbg_ptr); end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'(1 << (k % 4));
            tick();
            total++; if (gnt !== exp_g) begin bad++; $display("FAIL rot_gnt k=%0d got=%b want=%b", k, gnt, exp_g); end
            total++; if (gnt_id !== 2'(k % 4)) begin bad++; $display("FAIL rot_id k=%0d got=%0d want=%0d", k, gnt_id, k % 4); end
            done = exp_g;
            tick();
            done = '0;
            if (k == 4) req = '0;
            total++; if (gnt !== 4'b0000 || dbg_state !== S_REL) begin bad++; $display("FAIL rot_gap k=%0d gnt=%b state=%0d want 0000/2", k, gnt, dbg_state); end
            total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rot_tmo k=%0d got=%b want=0", k, timeout); end
            tick();
            total++; if (gnt !== 4'b0000 || dbg_state !== S_IDLE) begin bad++; $display("FAIL rot_idle k=%0d gnt=%b state=%0d want 0000/0", k, gnt, dbg_state); end
        end
        total++; if (dbg_ptr !== 2'd1) begin bad++; $display("FAIL rot_ptr got=%0d want=1", dbg_ptr); end
    endtask

    task automatic test_timeout();
        req = 4'b0001;
        tick();
        for (int c = 1; c <= 6; c++) begin
            total++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin bad++; $display("FAIL tmo_hold c=%0d gnt=%b tmo=%b want 0001/0", c, gnt, timeout); end
            tick();
        end
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL tmo_rel_gnt got=%b want=0000", gnt); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL tmo_pulse got=%b want=1", timeout); end
        tick();
        total++; if (timeout !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL tmo_end tmo=%b gnt=%b want 0/0000", timeout, gnt); end
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL tmo_regrant got=%b want=0001", gnt); end
        req = '0;
        tick();
        total++; if (gnt !== 4'b0000 || timeout !== 1'b0) begin bad++; $display("FAIL tmo_withdraw gnt=%b tmo=%b want 0000/0", gnt, timeout); end
        tick();
    endtask

    task automatic test_done_at_limit();
        req = 4'b0010;
        tick();
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL lim_gnt got=%b want=0010", gnt); end
        repeat (5) tick();
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL lim_hold6 got=%b want=0010", gnt); end
        done = 4'b0010;
        tick();
        done = '0; req = '0;
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL lim_rel got=%b want=0000", gnt); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL lim_tmo got=%b want=0", timeout); end
        tick();
        total++; if (dbg_ptr !== 2'd2) begin bad++; $display("FAIL lim_ptr got=%0d want=2", dbg_ptr); end
    endtask

    task automatic test_withdraw_ignored_done();
        req = 4'b0010;
        tick();
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL wd_gnt got=%b want=0010", gnt); end
        done = 4'b1000;
        tick();
        done = '0;
        total++; if (gnt !== 4'b0010 || dbg_state !== S_GRANT) begin bad++; $display("FAIL wd_ignore gnt=%b state=%0d want 0010/1", gnt, dbg_state); end
        req = '0;
        tick();
        total++; if (gnt !== 4'b0000 || timeout !== 1'b0) begin bad++; $display("FAIL wd_rel gnt=%b tmo=%b want 0000/0", gnt, timeout); end
        tick();
        req = 4'b1010;
        tick();
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL wd_prio3 got=%b want=1000", gnt); end
        done = 4'b1000;
        tick(); done = '0;
        tick(); tick();
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL wd_prio1 got=%b want=0010", gnt); end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_grant();
        req = 4'b0100;
        tick();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL mid_gnt got=%b want=0100", gnt); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL mid_drop gnt=%b busy=%b want 0000/0", gnt, busy); end
        total++; if (dbg_state !== S_IDLE || dbg_ptr !== 2'd0) begin bad++; $display("FAIL mid_state state=%0d ptr=%0d want 0/0", dbg_state, dbg_ptr); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL mid_tmo got=%b want=0", timeout); end
        tick();
        total++; if (gnt !== 4'b0100 || timeout !== 1'b0) begin bad++; $display("FAIL mid_regrant gnt=%b tmo=%b want 0100/0", gnt, timeout); end
        req = '0;
        tick(); tick();
    endtask

    initial begin
        rst = 1'b1; req = '0; done = '0;
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_done_at_limit();
        test_withdraw_ignored_done();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
